// File: rtl/reg_file_ctx.sv
// reg_file_ctx: DEPTH x WIDTH register file with two read ports, one write port,
// a shadow bank for single-edge context save/restore/swap, and a per-register dirty mask.
module reg_file_ctx #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 0
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [DEPTH*WIDTH-1:0] initialdata,
  input  logic                   RegWrite,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [ADDR_W-1:0]      rd_addr_a,
  input  logic [ADDR_W-1:0]      rd_addr_b,
  output logic [WIDTH-1:0]       rd_data_a,
  output logic [WIDTH-1:0]       rd_data_b,
  input  logic                   Save,
  input  logic                   Restore,
  output logic [DEPTH-1:0]       dirty
);
  localparam logic [ADDR_W:0] depth_lim = (ADDR_W+1)'(DEPTH);
  logic [WIDTH-1:0] regs   [DEPTH];
  logic [WIDTH-1:0] shadow [DEPTH];
  logic wr_ok, rd_ok_a, rd_ok_b;
  function automatic logic [WIDTH-1:0] rst_val(input int i);
    return (ZERO_REG != 0 && i == 0) ? '0 : initialdata[i*WIDTH +: WIDTH];
  endfunction
  // an address is live if it is inside the array and not the hardwired zero register
  assign wr_ok   = RegWrite && ({1'b0, wr_addr} < depth_lim) && !(ZERO_REG != 0 && wr_addr == '0);
  assign rd_ok_a = ({1'b0, rd_addr_a} < depth_lim) && !(ZERO_REG != 0 && rd_addr_a == '0);
  assign rd_ok_b = ({1'b0, rd_addr_b} < depth_lim) && !(ZERO_REG != 0 && rd_addr_b == '0);
  assign rd_data_a = (BYPASS != 0 && wr_ok && rd_addr_a == wr_addr) ? wr_data :
                     rd_ok_a ? regs[rd_addr_a] : '0;
  assign rd_data_b = (BYPASS != 0 && wr_ok && rd_addr_b == wr_addr) ? wr_data :
                     rd_ok_b ? regs[rd_addr_b] : '0;
  // save and restore on the same edge exchange the banks; a write then overrides its slot
  always_ff @(negedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i]   <= rst_val(i);
        shadow[i] <= rst_val(i);
      end
      dirty <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (Save) shadow[i] <= regs[i];
        if (Restore) regs[i] <= shadow[i];
      end
      if (Save || Restore) dirty <= '0;
      if (wr_ok) begin
        regs[wr_addr]  <= wr_data;
        dirty[wr_addr] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_reg_file_ctx.sv
// tb_reg_file_ctx: drives a default instance and a DEPTH=6/ZERO_REG/BYPASS instance in lockstep
// against an array-based reference model of the register file and its shadow bank.
`timescale 1ns/1ps
module tb_reg_file_ctx;
  logic CLK = 1'b0, reset = 1'b0, RegWrite = 1'b0, Save = 1'b0, Restore = 1'b0;
  logic [2:0] wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
  logic [15:0] wr_data = '0;
  logic [127:0] init8;
  logic [95:0] init6;
  logic [15:0] rda0, rdb0, rda1, rdb1;
  logic [7:0] dty0;
  logic [5:0] dty1;
  int total = 0, passed = 0;
  logic [15:0] m_reg [2][8];
  logic [15:0] m_sh  [2][8];
  logic [7:0]  m_dirty [2];
  int dep [2] = '{8, 6};
  bit zr  [2] = '{1'b0, 1'b1};
  bit byp [2] = '{1'b0, 1'b1};

  always #10 CLK = ~CLK;

  reg_file_ctx dut0 (
    .CLK(CLK), .reset(reset), .initialdata(init8), .RegWrite(RegWrite), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rda0),
    .rd_data_b(rdb0), .Save(Save), .Restore(Restore), .dirty(dty0));

  reg_file_ctx #(.DEPTH(6), .ZERO_REG(1), .BYPASS(1)) dut1 (
    .CLK(CLK), .reset(reset), .initialdata(init6), .RegWrite(RegWrite), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rda1),
    .rd_data_b(rdb1), .Save(Save), .Restore(Restore), .dirty(dty1));

  function automatic bit live(int k, int a);
    return a < dep[k] && !(zr[k] && a == 0);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        m_reg[k][i] = (zr[k] && i == 0) ? 16'h0 : 16'(16'h1000 + i);
        m_sh[k][i]  = m_reg[k][i];
      end
      m_dirty[k] = 8'h00;
    end
  endfunction

  function automatic void model_edge();
    logic [15:0] r [8];
    logic [15:0] s [8];
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        r[i] = m_reg[k][i];
        s[i] = m_sh[k][i];
      end
      for (int i = 0; i < 8; i++) begin
        if (Save) m_sh[k][i] = r[i];
        if (Restore) m_reg[k][i] = s[i];
      end
      if (Save || Restore) m_dirty[k] = 8'h00;
      if (RegWrite && live(k, int'(wr_addr))) begin
        m_reg[k][int'(wr_addr)] = wr_data;
        m_dirty[k][int'(wr_addr)] = 1'b1;
      end
    end
  endfunction

  function automatic logic [15:0] model_read(int k, int a);
    if (byp[k] && RegWrite && live(k, int'(wr_addr)) && a == int'(wr_addr)) return wr_data;
    return live(k, a) ? m_reg[k][a] : 16'h0;
  endfunction

  task automatic tick();
    @(negedge CLK);
    if (!reset) model_edge();
    #1;
  endtask

  task automatic idle();
    RegWrite = 1'b0;
    Save = 1'b0;
    Restore = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    #1;
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a);
      rd_addr_b = 3'(a);
      #1;
      total++; if (rda0 !== 16'(16'h1000 + a)) $display("FAIL reset_rd0[%0d]: got %h want %h", a, rda0, 16'(16'h1000 + a)); else passed++;
      total++; if (rdb1 !== model_read(1, a)) $display("FAIL reset_rd1[%0d]: got %h want %h", a, rdb1, model_read(1, a)); else passed++;
    end
    total++; if (dty0 !== 8'h00) $display("FAIL reset_dirty0: got %h want 00", dty0); else passed++;
    total++; if (dty1 !== 6'h00) $display("FAIL reset_dirty1: got %h want 00", dty1); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_write();
    RegWrite = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
    rd_addr_a = 3'd3; rd_addr_b = 3'd3;
    #1;
    total++; if (rda0 !== 16'h1003) $display("FAIL write_pre0: got %h want 1003", rda0); else passed++;
    total++; if (rdb1 !== 16'hBEEF) $display("FAIL write_bypass1: got %h want beef", rdb1); else passed++;
    tick();
    idle();
    #1;
    total++; if (rda0 !== 16'hBEEF) $display("FAIL write_post0: got %h want beef", rda0); else passed++;
    total++; if (rdb1 !== model_read(1, 3)) $display("FAIL write_post1: got %h want %h", rdb1, model_read(1, 3)); else passed++;
    total++; if (dty0 !== 8'h08) $display("FAIL write_dirty0: got %h want 08", dty0); else passed++;
    total++; if (dty1 !== m_dirty[1][5:0]) $display("FAIL write_dirty1: got %h want %h", dty1, m_dirty[1][5:0]); else passed++;
  endtask

  task automatic test_save_restore();
    reset = 1'b1;
    model_reset();
    #1;
    reset = 1'b0;
    Save = 1'b1;
    tick();
    Save = 1'b0;
    for (int r = 0; r < 8; r++) begin
      RegWrite = 1'b1; wr_addr = 3'(r); wr_data = 16'h0000;
      tick();
    end
    RegWrite = 1'b0;
    rd_addr_a = 3'd6;
    #1;
    total++; if (rda0 !== 16'h0000) $display("FAIL clobber0: got %h want 0000", rda0); else passed++;
    Restore = 1'b1;
    tick();
    Restore = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a);
      rd_addr_b = 3'(a);
      #1;
      total++; if (rda0 !== 16'(16'h1000 + a)) $display("FAIL restore_rd0[%0d]: got %h want %h", a, rda0, 16'(16'h1000 + a)); else passed++;
      total++; if (rdb1 !== model_read(1, a)) $display("FAIL restore_rd1[%0d]: got %h want %h", a, rdb1, model_read(1, a)); else passed++;
    end
    total++; if (dty0 !== 8'h00) $display("FAIL restore_dirty0: got %h want 00", dty0); else passed++;
    total++; if (dty1 !== 6'h00) $display("FAIL restore_dirty1: got %h want 00", dty1); else passed++;
  endtask

  task automatic test_swap();
    Save = 1'b1;
    tick();
    Save = 1'b0;
    RegWrite = 1'b1; wr_addr = 3'd5; wr_data = 16'h5555;
    tick();
    Save = 1'b1; Restore = 1'b1; wr_addr = 3'd2; wr_data = 16'hAAAA;
    tick();
    idle();
    rd_addr_a = 3'd5; rd_addr_b = 3'd2;
    #1;
    total++; if (rda0 !== 16'h1005) $display("FAIL swap_r5: got %h want 1005", rda0); else passed++;
    total++; if (rdb0 !== 16'hAAAA) $display("FAIL swap_r2: got %h want aaaa", rdb0); else passed++;
    total++; if (dty0 !== 8'h04) $display("FAIL swap_dirty0: got %h want 04", dty0); else passed++;
    total++; if (rda1 !== model_read(1, 5)) $display("FAIL swap_r5_1: got %h want %h", rda1, model_read(1, 5)); else passed++;
    total++; if (dty1 !== m_dirty[1][5:0]) $display("FAIL swap_dirty1: got %h want %h", dty1, m_dirty[1][5:0]); else passed++;
    Restore = 1'b1;
    tick();
    Restore = 1'b0;
    #1;
    total++; if (rda0 !== 16'h5555) $display("FAIL swap_restore_r5: got %h want 5555", rda0); else passed++;
    total++; if (rda1 !== model_read(1, 5)) $display("FAIL swap_restore_r5_1: got %h want %h", rda1, model_read(1, 5)); else passed++;
  endtask

  task automatic test_out_of_range();
    logic [5:0] d1_before;
    RegWrite = 1'b1; wr_addr = 3'd1; wr_data = 16'h0101;
    tick();
    d1_before = m_dirty[1][5:0];
    wr_addr = 3'd7; wr_data = 16'hDEAD;
    tick();
    idle();
    rd_addr_a = 3'd6; rd_addr_b = 3'd7;
    #1;
    total++; if (dty1 !== d1_before) $display("FAIL oor_dirty1: got %h want %h", dty1, d1_before); else passed++;
    total++; if (rda1 !== 16'h0000) $display("FAIL oor_rd6: got %h want 0000", rda1); else passed++;
    total++; if (rdb1 !== 16'h0000) $display("FAIL oor_rd7: got %h want 0000", rdb1); else passed++;
    total++; if (rdb0 !== 16'hDEAD) $display("FAIL oor_d0_r7: got %h want dead", rdb0); else passed++;
    for (int a = 0; a < 6; a++) begin
      rd_addr_a = 3'(a);
      #1;
      total++; if (rda1 !== model_read(1, a)) $display("FAIL oor_keep1[%0d]: got %h want %h", a, rda1, model_read(1, a)); else passed++;
    end
  endtask

  task automatic test_modes();
    RegWrite = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF; rd_addr_a = 3'd0;
    #1;
    total++; if (rda1 !== 16'h0000) $display("FAIL zero_nobypass: got %h want 0000", rda1); else passed++;
    tick();
    idle();
    #1;
    total++; if (rda1 !== 16'h0000) $display("FAIL zero_rd: got %h want 0000", rda1); else passed++;
    total++; if (dty1[0] !== 1'b0) $display("FAIL zero_dirty: got %b want 0", dty1[0]); else passed++;
    total++; if (rda0 !== 16'hFFFF) $display("FAIL zero_d0: got %h want ffff", rda0); else passed++;
    RegWrite = 1'b1; wr_addr = 3'd4; wr_data = 16'h1234; rd_addr_b = 3'd4; Restore = 1'b1;
    #1;
    total++; if (rdb1 !== 16'h1234) $display("FAIL bypass_b: got %h want 1234", rdb1); else passed++;
    total++; if (rdb0 !== model_read(0, 4)) $display("FAIL nobypass_b: got %h want %h", rdb0, model_read(0, 4)); else passed++;
    tick();
    idle();
    #1;
    total++; if (rdb0 !== 16'h1234) $display("FAIL bypass_post0: got %h want 1234", rdb0); else passed++;
    total++; if (rdb1 !== 16'h1234) $display("FAIL bypass_post1: got %h want 1234", rdb1); else passed++;
  endtask

  task automatic test_reset_mid();
    for (int r = 1; r < 4; r++) begin
      RegWrite = 1'b1; wr_addr = 3'(r); wr_data = 16'(16'h7000 + r);
      tick();
    end
    #4;
    reset = 1'b1;
    model_reset();
    #1;
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a);
      rd_addr_b = 3'(a);
      #1;
      total++; if (rda0 !== 16'(16'h1000 + a)) $display("FAIL midreset_rd0[%0d]: got %h want %h", a, rda0, 16'(16'h1000 + a)); else passed++;
      total++; if (rdb1 !== model_read(1, a)) $display("FAIL midreset_rd1[%0d]: got %h want %h", a, rdb1, model_read(1, a)); else passed++;
    end
    total++; if (dty0 !== 8'h00) $display("FAIL midreset_dirty0: got %h want 00", dty0); else passed++;
    #1;
    reset = 1'b0;
    idle();
    Save = 1'b1; RegWrite = 1'b1; wr_addr = 3'd1; wr_data = 16'h7777;
    tick();
    idle();
    Restore = 1'b1;
    tick();
    Restore = 1'b0;
    rd_addr_a = 3'd1;
    #1;
    total++; if (rda0 !== 16'h1001) $display("FAIL postreset_shadow0: got %h want 1001", rda0); else passed++;
    total++; if (rda1 !== model_read(1, 1)) $display("FAIL postreset_shadow1: got %h want %h", rda1, model_read(1, 1)); else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      RegWrite  = 1'($urandom_range(0, 1));
      wr_addr   = 3'($urandom_range(0, 7));
      wr_data   = 16'($urandom);
      Save      = ($urandom_range(0, 5) == 0);
      Restore   = ($urandom_range(0, 5) == 0);
      rd_addr_a = 3'($urandom_range(0, 7));
      rd_addr_b = 3'($urandom_range(0, 7));
      #1;
      total++; if (rda1 !== model_read(1, int'(rd_addr_a))) $display("FAIL rnd_pre_a1 n=%0d: got %h want %h", n, rda1, model_read(1, int'(rd_addr_a))); else passed++;
      total++; if (rdb0 !== model_read(0, int'(rd_addr_b))) $display("FAIL rnd_pre_b0 n=%0d: got %h want %h", n, rdb0, model_read(0, int'(rd_addr_b))); else passed++;
      tick();
      total++; if (rda0 !== model_read(0, int'(rd_addr_a))) $display("FAIL rnd_a0 n=%0d: got %h want %h", n, rda0, model_read(0, int'(rd_addr_a))); else passed++;
      total++; if (rdb1 !== model_read(1, int'(rd_addr_b))) $display("FAIL rnd_b1 n=%0d: got %h want %h", n, rdb1, model_read(1, int'(rd_addr_b))); else passed++;
      total++; if (dty0 !== m_dirty[0]) $display("FAIL rnd_dirty0 n=%0d: got %h want %h", n, dty0, m_dirty[0]); else passed++;
      total++; if (dty1 !== m_dirty[1][5:0]) $display("FAIL rnd_dirty1 n=%0d: got %h want %h", n, dty1, m_dirty[1][5:0]); else passed++;
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) init8[i*16 +: 16] = 16'(16'h1000 + i);
    for (int i = 0; i < 6; i++) init6[i*16 +: 16] = 16'(16'h1000 + i);
    #1;
    test_reset();
    test_write();
    test_save_restore();
    test_swap();
    test_out_of_range();
    test_modes();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/reg_file_ctx.md
# reg_file_ctx

Parametrised multi-register file, the next generation of the single 16-bit register: DEPTH registers of WIDTH bits each, with per-register reset values, two combinational read ports and one write port. A shadow bank supports single-edge context save, restore and swap for interrupt/trap entry and exit. A per-register dirty mask shows which registers were written since the last save or restore. It sits between the decode stage and the ALU operand muxes of the processor datapath.

## Interface
- WIDTH, 16: bits per register.
- DEPTH, 8: number of registers, 2..256.
- ADDR_W, 3: address width; must satisfy 2**ADDR_W >= DEPTH.
- ZERO_REG, 0: when 1, register 0 always reads 0 and ignores writes.
- BYPASS, 0: when 1, read ports forward pending write data (see Operation).

Ports:
- CLK  in  1  clock. All state updates on the falling edge.
- reset  in  1  asynchronous, active-high reset.
- initialdata  in  DEPTH*WIDTH  reset values. Register i takes initialdata[i*WIDTH +: WIDTH].
- RegWrite  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data.
- rd_addr_a, rd_addr_b  in  ADDR_W  read addresses.
- rd_data_a, rd_data_b  out  WIDTH  read data (combinational).
- Save  in  1  copy all registers into the shadow bank.
- Restore  in  1  copy the shadow bank into all registers.
- dirty  out  DEPTH  bit i set means register i was written since the last save or restore.

## Operation
- Reset (asynchronous, level): every register and every shadow entry takes its initialdata slice. dirty = 0.
  - With ZERO_REG = 1, register 0 and shadow entry 0 reset to 0 regardless of initialdata.
  - Reset overrides all other inputs.
- Each falling edge of CLK, in this order:
  - Save only: shadow[i] <= reg[i] for all i, using the pre-edge values. dirty <= 0.
  - Restore only: reg[i] <= shadow[i] for all i. dirty <= 0.
  - Save and Restore together (context swap): reg <= shadow and shadow <= reg at the same time. dirty <= 0.
  - Then RegWrite with a valid address: reg[wr_addr] <= wr_data, overriding any restored or swapped value at that address. dirty[wr_addr] <= 1.
  - A write on the same edge as a save does not change the saved value. The shadow holds the pre-write contents.
- Writes that are dropped and leave dirty unchanged:
  - wr_addr >= DEPTH.
  - wr_addr = 0 when ZERO_REG = 1.
- Reads are combinational from the current register array.
  - An address >= DEPTH reads 0.
  - Address 0 reads 0 when ZERO_REG = 1.
- BYPASS = 1: if RegWrite is high, the write address is valid and rd_addr_x = wr_addr, then rd_data_x = wr_data.
  - Bypass does not apply to dropped writes.
  - Bypass takes priority over a pending Restore.
- BYPASS = 0: a read returns the old value until the falling edge, then the new value.

## Timing
- Write latency: the new value is visible on the read ports immediately after the falling edge that samples RegWrite. There are no wait states.
- Save, Restore and swap each complete on a single falling edge. There is no busy state, and they may be issued back to back.
- Reset response: outputs follow the reset values within the same delta/cycle that reset asserts, with no clock required.
  - dirty = 0.
  - rd_data_x = initialdata slice of rd_addr_x.
- Reset release: the first state update happens on the first falling edge after reset deasserts.
- Reset during a Save, Restore or write on the same edge: reset wins, and the resulting state equals the reset state.
- Inputs must be stable around the falling edge. Read outputs settle combinationally from the addresses, the register array and (when BYPASS = 1) the write inputs.

## Test plan
Defaults for all scenarios: WIDTH = 16, DEPTH = 8, ZERO_REG = 0, BYPASS = 0, initialdata slice i = 16'h1000 + i.

1. Reset and write:
   - Assert reset, read all eight addresses -> 16'h1000..16'h1007; dirty = 8'h00.
   - Write 16'hBEEF to r3 -> rd_data_a(3) = 16'h1003 before the falling edge and 16'hBEEF after it; dirty = 8'h08.
2. Save, clobber, restore:
   - Save, then write 16'h0000 to r0..r7, then Restore -> all registers back to 16'h1000..16'h1007; dirty = 8'h00.
3. Swap with a same-edge write:
   - Save, write r5 = 16'h5555, then Save + Restore + write r2 = 16'hAAAA on one edge.
   - Result -> r5 = 16'h1005; r2 = 16'hAAAA; shadow[5] = 16'h5555; dirty = 8'h04.
   - A following Restore -> r5 = 16'h5555.
4. Out-of-range access:
   - Use DEPTH = 6 with ADDR_W = 3.
   - Write address 7 -> no register changes and dirty is unchanged.
   - Read address 6 -> 16'h0000.
5. Modes:
   - ZERO_REG = 1: write r0 = 16'hFFFF -> r0 reads 0 and dirty[0] = 0.
   - BYPASS = 1: RegWrite to r4 = 16'h1234 with rd_addr_b = 4 -> rd_data_b = 16'h1234 before the edge.
6. Reset mid-operation:
   - Assert reset asynchronously between edges after several writes -> outputs return to the initialdata values at once.
   - Save + RegWrite on the first edge after release -> shadow = initialdata values.
